// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared reg-bus state encoding, response status codes and width helper
package reg_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, GAP, RSP} state_e;
  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_BUS_TO = 2'b01;
  localparam logic [1:0] RSP_LCL_TO = 2'b10;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_bus_cmd_master_if.sv
// reg_bus_cmd_master_if: command, response and reg-bus signals of the reg-bus initiator
interface reg_bus_cmd_master_if #(
  parameter int AW  = 26,
  parameter int DW  = 32,
  parameter int BEW = 4
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_wr;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic [BEW-1:0] cmd_be;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic [1:0]     rsp_status;
  logic           reg_cs;
  logic [AW-1:0]  reg_addr;
  logic [DW-1:0]  reg_wdata;
  logic           reg_wr;
  logic [BEW-1:0] reg_be;
  logic [DW-1:0]  reg_rdata;
  logic           reg_ack;
  logic           reg_timeout;
  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be, rsp_ready, reg_rdata, reg_ack, reg_timeout,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, reg_cs, reg_addr, reg_wdata, reg_wr, reg_be
  );
  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be, rsp_ready, reg_rdata, reg_ack, reg_timeout,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, reg_cs, reg_addr, reg_wdata, reg_wr, reg_be
  );
endinterface

// File: rtl/reg_bus_cmd_master.sv
// reg_bus_cmd_master: single-outstanding reg-bus initiator with bounded retry and local watchdog
module reg_bus_cmd_master
  import reg_bus_pkg::*;
#(
  parameter int AW          = 26,
  parameter int DW          = 32,
  parameter int BEW         = 4,
  parameter bit TIMEOUT_ENB = 1'b1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RETRY_MAX   = 2
) (
  input logic                 in_clk,
  input logic                 in_reset_n,
  reg_bus_cmd_master_if.master bus
);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam int RW = cnt_w(RETRY_MAX + 1);
  state_e         state_q, state_d;
  logic           cs_q, cs_d, wr_q, wr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BEW-1:0] be_q, be_d;
  logic [1:0]     status_q, status_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [RW-1:0]  retry_q, retry_d;
  assign bus.cmd_ready  = state_q == IDLE;
  assign bus.rsp_valid  = state_q == RSP;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_status = status_q;
  assign bus.reg_cs     = cs_q;
  assign bus.reg_addr   = addr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.reg_wr     = wr_q;
  assign bus.reg_be     = be_q;
  // state and datapath registers; async reset so reg_cs drops the moment reset asserts
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= IDLE;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      status_q <= RSP_OK;
      timer_q  <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
    end
  end
  // next state: accept, issue, retry on target timeout, watchdog, hold response until consumed
  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        wr_d    = bus.cmd_wr;
        addr_d  = bus.cmd_addr;
        wdata_d = bus.cmd_wdata;
        be_d    = bus.cmd_be;
        cs_d    = 1'b1;
        timer_d = '0;
        retry_d = '0;
        state_d = REQ;
      end
      REQ: begin
        timer_d = timer_q + 1'b1;
        if (bus.reg_ack && !bus.reg_timeout) begin
          cs_d     = 1'b0;
          rdata_d  = wr_q ? '0 : bus.reg_rdata;
          status_d = RSP_OK;
          state_d  = RSP;
        end else if (bus.reg_ack && retry_q < RW'(RETRY_MAX)) begin
          cs_d    = 1'b0;
          retry_d = retry_q + 1'b1;
          state_d = GAP;
        end else if (bus.reg_ack) begin
          cs_d     = 1'b0;
          rdata_d  = '0;
          status_d = RSP_BUS_TO;
          state_d  = RSP;
        end else if (TIMEOUT_ENB && timer_q == TW'(TIMEOUT_CYC - 1)) begin
          cs_d     = 1'b0;
          rdata_d  = '0;
          status_d = RSP_LCL_TO;
          state_d  = RSP;
        end
      end
      GAP: begin
        cs_d    = 1'b1;
        timer_d = '0;
        state_d = REQ;
      end
      RSP: state_d = bus.rsp_ready ? IDLE : RSP;
      default: begin
        state_d  = IDLE;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        be_d     = '0;
        rdata_d  = '0;
        status_d = RSP_OK;
        timer_d  = '0;
        retry_d  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_reg_bus_cmd_master.sv
// tb_reg_bus_cmd_master: directed scenarios for the reg-bus initiator
module tb_reg_bus_cmd_master;
  logic in_clk = 1'b0;
  logic in_reset_n = 1'b0;
  int checks = 0;
  int errs = 0;
  int n;
  reg_bus_cmd_master_if #(.AW(26), .DW(32), .BEW(4)) b ();
  reg_bus_cmd_master #(.AW(26), .DW(32), .BEW(4), .TIMEOUT_ENB(1'b1), .TIMEOUT_CYC(16), .RETRY_MAX(2)) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .bus(b.master));
  always #5 in_clk = ~in_clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask
  task automatic cmd(input logic wr, input logic [25:0] a, input logic [31:0] d, input logic [3:0] be);
    b.cmd_valid = 1'b1; b.cmd_wr = wr; b.cmd_addr = a; b.cmd_wdata = d; b.cmd_be = be;
  endtask
  task automatic test_reset();
    b.cmd_valid = 0; b.cmd_wr = 0; b.cmd_addr = 0; b.cmd_wdata = 0; b.cmd_be = 0; b.rsp_ready = 0;
    b.reg_rdata = 0; b.reg_ack = 0; b.reg_timeout = 0;
    #2;
    checks++; if (b.reg_cs !== 1'b0) begin errs++; $display("FAIL rst_cs got %b exp 0", b.reg_cs); end
    checks++; if (b.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b exp 0", b.rsp_valid); end
    checks++; if (b.reg_addr !== 26'h0 || b.reg_wr !== 1'b0 || b.reg_be !== 4'h0) begin errs++; $display("FAIL rst_reg got addr %h wr %b be %h exp 0", b.reg_addr, b.reg_wr, b.reg_be); end
    checks++; if (b.rsp_rdata !== 32'h0 || b.rsp_status !== 2'b00) begin errs++; $display("FAIL rst_rsp got %h/%b exp 0/00", b.rsp_rdata, b.rsp_status); end
    tick(); tick();
    in_reset_n = 1'b1;
    tick();
    checks++; if (b.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready got %b exp 1", b.cmd_ready); end
  endtask
  task automatic test_read();
    cmd(1'b0, 26'h10, 32'h0, 4'hF);
    tick();
    b.cmd_valid = 0;
    checks++; if (b.cmd_ready !== 1'b0) begin errs++; $display("FAIL rd_cmd_ready got %b exp 0", b.cmd_ready); end
    n = 0;
    repeat (4) begin if (b.reg_cs === 1'b1) n++; tick(); end
    if (b.reg_cs === 1'b1) n++;
    b.reg_ack = 1; b.reg_rdata = 32'hDEADBEEF;
    tick();
    b.reg_ack = 0; b.reg_rdata = 0;
    checks++; if (n !== 5) begin errs++; $display("FAIL rd_cs_len got %0d exp 5", n); end
    checks++; if (b.reg_cs !== 1'b0 || b.rsp_valid !== 1'b1) begin errs++; $display("FAIL rd_latency got cs %b rv %b exp 0 1", b.reg_cs, b.rsp_valid); end
    checks++; if (b.rsp_rdata !== 32'hDEADBEEF || b.rsp_status !== 2'b00) begin errs++; $display("FAIL rd_rsp got %h/%b exp deadbeef/00", b.rsp_rdata, b.rsp_status); end
    checks++; if (b.reg_addr !== 26'h10) begin errs++; $display("FAIL rd_addr got %h exp 10", b.reg_addr); end
    b.rsp_ready = 1;
    tick();
    b.rsp_ready = 0;
    checks++; if (b.rsp_valid !== 1'b0 || b.cmd_ready !== 1'b1) begin errs++; $display("FAIL rd_done got rv %b cr %b exp 0 1", b.rsp_valid, b.cmd_ready); end
  endtask
  task automatic test_back_to_back();
    b.rsp_ready = 1;
    cmd(1'b1, 26'h20, 32'h12345678, 4'hF);
    tick();
    cmd(1'b0, 26'h24, 32'h0, 4'h3);
    checks++; if (b.reg_cs !== 1'b1 || b.reg_wr !== 1'b1 || b.reg_addr !== 26'h20 || b.reg_wdata !== 32'h12345678 || b.reg_be !== 4'hF) begin
      errs++; $display("FAIL wr_bus got cs %b wr %b a %h d %h be %h exp 1 1 20 12345678 f", b.reg_cs, b.reg_wr, b.reg_addr, b.reg_wdata, b.reg_be); end
    tick();
    b.reg_ack = 1; b.reg_rdata = 32'hFFFFFFFF;
    tick();
    b.reg_ack = 0; b.reg_rdata = 0;
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_rdata !== 32'h0 || b.rsp_status !== 2'b00) begin errs++; $display("FAIL wr_rsp got rv %b %h/%b exp 1 0/00", b.rsp_valid, b.rsp_rdata, b.rsp_status); end
    tick();
    checks++; if (b.rsp_valid !== 1'b0 || b.reg_cs !== 1'b0 || b.cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_gap got rv %b cs %b cr %b exp 0 0 1", b.rsp_valid, b.reg_cs, b.cmd_ready); end
    tick();
    b.cmd_valid = 0;
    checks++; if (b.reg_cs !== 1'b1 || b.reg_addr !== 26'h24 || b.reg_wr !== 1'b0 || b.reg_be !== 4'h3) begin errs++; $display("FAIL b2b_second got cs %b a %h wr %b be %h exp 1 24 0 3", b.reg_cs, b.reg_addr, b.reg_wr, b.reg_be); end
    b.reg_ack = 1; b.reg_rdata = 32'hA5A50001;
    tick();
    b.reg_ack = 0;
    checks++; if (b.rsp_rdata !== 32'hA5A50001 || b.rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b_rsp got %h rv %b exp a5a50001 1", b.rsp_rdata, b.rsp_valid); end
    tick();
    b.rsp_ready = 0;
  endtask
  task automatic test_retry();
    cmd(1'b0, 26'h30, 32'h0, 4'hF);
    tick();
    b.cmd_valid = 0;
    for (int p = 0; p < 3; p++) begin
      checks++; if (b.reg_cs !== 1'b1 || b.reg_addr !== 26'h30) begin errs++; $display("FAIL retry_pulse%0d got cs %b a %h exp 1 30", p, b.reg_cs, b.reg_addr); end
      b.reg_ack = 1; b.reg_timeout = 1; b.reg_rdata = 32'h77777777;
      tick();
      b.reg_ack = 0; b.reg_timeout = 0;
      if (p < 2) begin
        checks++; if (b.reg_cs !== 1'b0 || b.rsp_valid !== 1'b0) begin errs++; $display("FAIL retry_gap%0d got cs %b rv %b exp 0 0", p, b.reg_cs, b.rsp_valid); end
        tick();
      end
    end
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_status !== 2'b01 || b.rsp_rdata !== 32'h0 || b.reg_cs !== 1'b0) begin
      errs++; $display("FAIL retry_rsp got rv %b %h/%b cs %b exp 1 0/01 0", b.rsp_valid, b.rsp_rdata, b.rsp_status, b.reg_cs); end
    b.rsp_ready = 1; tick(); b.rsp_ready = 0;
  endtask
  task automatic test_local_timeout();
    cmd(1'b0, 26'h40, 32'h0, 4'hF);
    tick();
    b.cmd_valid = 0;
    n = 0;
    for (int i = 0; i < 40 && b.reg_cs === 1'b1; i++) begin n++; tick(); end
    checks++; if (n !== 16) begin errs++; $display("FAIL lto_cs_len got %0d exp 16", n); end
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_status !== 2'b10 || b.rsp_rdata !== 32'h0) begin errs++; $display("FAIL lto_rsp got rv %b %h/%b exp 1 0/10", b.rsp_valid, b.rsp_rdata, b.rsp_status); end
    b.reg_ack = 1; b.reg_rdata = 32'h11111111;
    tick();
    b.reg_ack = 0;
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_status !== 2'b10 || b.rsp_rdata !== 32'h0 || b.reg_cs !== 1'b0) begin
      errs++; $display("FAIL late_ack got rv %b %h/%b cs %b exp 1 0/10 0", b.rsp_valid, b.rsp_rdata, b.rsp_status, b.reg_cs); end
    b.rsp_ready = 1; tick(); b.rsp_ready = 0;
  endtask
  task automatic test_ack_at_expiry();
    cmd(1'b0, 26'h50, 32'h0, 4'hF);
    tick();
    b.cmd_valid = 0;
    repeat (15) tick();
    checks++; if (b.reg_cs !== 1'b1) begin errs++; $display("FAIL exp_cs got %b exp 1", b.reg_cs); end
    b.reg_ack = 1; b.reg_rdata = 32'hCAFEF00D;
    tick();
    b.reg_ack = 0;
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_status !== 2'b00 || b.rsp_rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL exp_rsp got rv %b %h/%b exp 1 cafef00d/00", b.rsp_valid, b.rsp_rdata, b.rsp_status); end
    b.rsp_ready = 1; tick(); b.rsp_ready = 0;
  endtask
  task automatic test_stall_and_reset();
    cmd(1'b0, 26'h60, 32'h0, 4'hF);
    tick();
    cmd(1'b1, 26'h64, 32'h99, 4'h1);
    b.reg_ack = 1; b.reg_rdata = 32'h5555AAAA;
    tick();
    b.reg_ack = 0;
    n = 0;
    repeat (10) begin
      if (b.rsp_valid !== 1'b1 || b.rsp_rdata !== 32'h5555AAAA || b.rsp_status !== 2'b00 || b.cmd_ready !== 1'b0 || b.reg_cs !== 1'b0) n++;
      tick();
    end
    checks++; if (n !== 0) begin errs++; $display("FAIL stall_hold got %0d bad cycles exp 0", n); end
    b.rsp_ready = 1;
    tick();
    b.rsp_ready = 0;
    tick();
    b.cmd_valid = 0;
    checks++; if (b.reg_cs !== 1'b1 || b.reg_addr !== 26'h64) begin errs++; $display("FAIL stall_next got cs %b a %h exp 1 64", b.reg_cs, b.reg_addr); end
    tick(); tick();
    in_reset_n = 1'b0;
    #1;
    checks++; if (b.reg_cs !== 1'b0 || b.cmd_ready !== 1'b1 || b.rsp_valid !== 1'b0) begin errs++; $display("FAIL async_rst got cs %b cr %b rv %b exp 0 1 0", b.reg_cs, b.cmd_ready, b.rsp_valid); end
    tick(); tick();
    in_reset_n = 1'b1;
    tick();
    checks++; if (b.cmd_ready !== 1'b1 || b.reg_cs !== 1'b0 || b.reg_addr !== 26'h0) begin errs++; $display("FAIL post_rst got cr %b cs %b a %h exp 1 0 0", b.cmd_ready, b.reg_cs, b.reg_addr); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_retry();
    test_local_timeout();
    test_ack_at_expiry();
    test_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
